gf2_machine_scheduler: RTL

- Sequences one GF(2) machine (button/light system) at a time: gf2_rref, then enumerate_solutions, then consumes the solution stream.
- Tracks the minimum-weight solution per machine and reports it.
- Accumulates the sum of per-machine minima across a batch.
- Sits between the machine-matrix loader and the answer output. Owns the start/handshake sequencing of both solver stages.

---
 rtl/gf2_solver_pkg.sv | 22 ++
 rtl/axi_stream_if.sv | 15 +
 rtl/gf2_consistency_check.sv | 20 ++
 rtl/popcount.sv | 17 +
 rtl/gf2_machine_scheduler.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/gf2_solver_pkg.sv
// Shared definitions for the GF(2) machine solver blocks.
//   sched_state_e : scheduler FSM state encoding (also exported as a debug port)
//   VARS_COUNT    : number of unknowns (matrix columns minus the RHS column)
//   VARS_COUNT_W  : width needed to hold a popcount of VARS_COUNT bits
package gf2_solver_pkg;

  localparam int ROWS         = 10;
  localparam int COLS         = 14;
  localparam int VARS_COUNT   = COLS - 1;
  localparam int VARS_COUNT_W = $clog2(VARS_COUNT + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_RREF = 3'd1,
    WAIT_RREF  = 3'd2,
    START_ENUM = 3'd3,
    COLLECT    = 3'd4,
    REPORT     = 3'd5,
    FINISH     = 3'd6
  } sched_state_e;

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-stream style interface.
// Handshake: a beat transfers on a rising clk edge where tvalid && tready are
// both high; the master holds tdata/tlast stable while tvalid is high and
// tready is low; tready may be asserted independently of tvalid.
interface axi_stream_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/gf2_consistency_check.sv
// Flags an inconsistent reduced system: any row whose coefficient bits are
// all zero while its RHS bit (bit 0) is one, i.e. the equation 0 = 1.
//   matrix       : ROWS rows of COLS bits, row r at [r*COLS +: COLS]
//   inconsistent : high when at least one such row exists
module gf2_consistency_check #(
  parameter int ROWS = 10,
  parameter int COLS = 14
) (
  input  logic [ROWS*COLS-1:0] matrix,
  output logic                 inconsistent
);
  always_comb begin
    inconsistent = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if ((matrix[r*COLS+1 +: COLS-1] == '0) && matrix[r*COLS]) begin
        inconsistent = 1'b1;
      end
    end
  end
endmodule

// File: rtl/popcount.sv
// Combinational population count.
//   data  : N-bit input vector
//   count : number of set bits in data
module popcount #(
  parameter int N = 13,
  parameter int W = 4
) (
  input  logic [N-1:0] data,
  output logic [W-1:0] count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + W'(data[i]);
    end
  end
endmodule

// File: rtl/gf2_machine_scheduler.sv
// Sequences one GF(2) machine at a time through gf2_rref and
// enumerate_solutions, tracks the minimum-weight solution of each machine and
// accumulates the sum of feasible minima across a batch.
//
// Handshakes (all valid/ready): a transfer happens on a rising clk edge where
// valid && ready are both high. Offered data is held stable while valid is
// high and ready is low. Here: in_valid/in_ready (machine in),
// sol.tvalid/sol.tready (solution beats), result_valid/result_ready (result).
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          machine offer; in_matrix, in_last with it
//   rref_start, rref_matrix    start pulse and latched matrix for gf2_rref
//   rref_done, rref_result     RREF result from gf2_rref
//   enum_start, enum_rref      start pulse and latched RREF for the enumerator
//   sol                        solution stream (slave)
//   result_valid/result_ready  per-machine result; result_min, result_infeasible
//   total_valid, total         batch total, pulsed after the in_last machine
//   state_dbg                  current FSM state
module gf2_machine_scheduler
  import gf2_solver_pkg::*;
#(
  parameter int ROWS       = 10,
  parameter int COLS       = 14,
  parameter int DATA_WIDTH = 16,
  parameter int TOTAL_W    = 32,
  localparam int N_VARS    = COLS - 1,
  localparam int N_VARS_W  = $clog2(N_VARS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROWS*COLS-1:0] in_matrix,
  input  logic                 in_last,
  output logic                 rref_start,
  output logic [ROWS*COLS-1:0] rref_matrix,
  input  logic                 rref_done,
  input  logic [ROWS*COLS-1:0] rref_result,
  output logic                 enum_start,
  output logic [ROWS*COLS-1:0] enum_rref,
  axi_stream_if.slave          sol,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [N_VARS_W-1:0]  result_min,
  output logic                 result_infeasible,
  output logic                 total_valid,
  output logic [TOTAL_W-1:0]   total,
  output sched_state_e         state_dbg
);

  sched_state_e          state, state_n;
  logic                  in_ready_q;  // registered so it reads 0 in the cycle after reset
  logic                  last_q;
  logic                  infeas_q;
  logic                  clear_total_q;  // set by FINISH, clears total on next accept
  logic [N_VARS_W-1:0]   min_q;
  logic [N_VARS_W-1:0]   beat_w;
  logic                  inconsistent;
  logic                  accept;
  logic                  beat;

  popcount #(.N(N_VARS), .W(N_VARS_W)) u_popcount (
    .data  (sol.tdata[N_VARS-1:0]),
    .count (beat_w)
  );

  gf2_consistency_check #(.ROWS(ROWS), .COLS(COLS)) u_check (
    .matrix       (rref_result),
    .inconsistent (inconsistent)
  );

  assign accept = (state == IDLE) && in_valid && in_ready_q;
  assign beat   = (state == COLLECT) && sol.tvalid;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (accept) state_n = START_RREF;
      START_RREF: state_n = WAIT_RREF;
      WAIT_RREF:  if (rref_done) state_n = inconsistent ? REPORT : START_ENUM;
      START_ENUM: state_n = COLLECT;
      COLLECT:    if (beat && sol.tlast) state_n = REPORT;
      REPORT:     if (result_ready) state_n = last_q ? FINISH : IDLE;
      FINISH:     state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      in_ready_q    <= 1'b0;
      last_q        <= 1'b0;
      infeas_q      <= 1'b0;
      clear_total_q <= 1'b0;
      min_q         <= '0;
      total         <= '0;
      rref_matrix   <= '0;
      enum_rref     <= '0;
    end else begin
      state      <= state_n;
      in_ready_q <= (state_n == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            rref_matrix <= in_matrix;
            last_q      <= in_last;
            if (clear_total_q) begin
              total         <= '0;
              clear_total_q <= 1'b0;
            end
          end
        end
        WAIT_RREF: begin
          if (rref_done) begin
            enum_rref <= rref_result;
            infeas_q  <= inconsistent;
            min_q     <= '1;  // infeasible machines report all-ones
          end
        end
        START_ENUM: min_q <= '1;
        COLLECT: begin
          // Strict less-than keeps the first beat found at the minimum weight.
          if (beat && (beat_w < min_q)) min_q <= beat_w;
        end
        REPORT: begin
          if (result_ready && !infeas_q) total <= total + TOTAL_W'(min_q);
        end
        FINISH: clear_total_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign in_ready          = in_ready_q;
  assign rref_start        = (state == START_RREF);
  assign enum_start        = (state == START_ENUM);
  assign sol.tready        = (state == COLLECT);
  assign result_valid      = (state == REPORT);
  assign result_min        = (state == REPORT) ? min_q : '0;
  assign result_infeasible = (state == REPORT) && infeas_q;
  assign total_valid       = (state == FINISH);
  assign state_dbg         = state;

endmodule
